// File: rtl/cordic_ctrl_pkg.sv
// Shared constants, types and helpers for the CORDIC quadrant controller.
// Latency: n/a (package).
// Backpressure: n/a (package).
package cordic_ctrl_pkg;

    // Bit positions inside the one-hot function select
    localparam int SEL_SIN  = 0;
    localparam int SEL_COS  = 1;
    localparam int SEL_TAN  = 2;
    localparam int SEL_ATAN = 3;

    // A negative angle gets a multiple of 360 added so the 17-bit sum is always
    // positive; 33120 = 360*92 covers -32768.
    localparam logic [16:0] DEG_360  = 17'd360;
    localparam logic [16:0] NORM_OFS = 17'd33120;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NORM   = 3'd1,
        ST_REDUCE = 3'd2,
        ST_FOLD   = 3'd3,
        ST_ISSUE  = 3'd4
    } state_t;

    // Tag carried alongside each request while the CORDIC core works on it
    typedef struct packed {
        quadrant_t  q;
        logic [3:0] sel;
    } tag_t;

    // Whether the folded-angle result must be negated to land in the original quadrant
    function automatic logic needs_neg(input logic [3:0] sel, input quadrant_t q);
        logic neg;
        neg = 1'b0;
        if (sel[SEL_SIN])      neg = (q == Q2) || (q == Q3);
        else if (sel[SEL_COS]) neg = (q == Q1) || (q == Q2);
        else if (sel[SEL_TAN]) neg = (q == Q1) || (q == Q3);
        return neg;
    endfunction

    // Two's complement negate; the most negative value saturates to the most positive
    function automatic logic [15:0] sat_neg(input logic [15:0] x);
        logic [15:0] y;
        if (x == 16'h8000) y = 16'h7FFF;
        else               y = ~x + 16'd1;
        return y;
    endfunction

endpackage

// File: rtl/cordic_tag_fifo.sv
// In-order tag FIFO holding one tag per request outstanding in the CORDIC core.
// Latency: pushed entry visible at the head the cycle after the push; head read combinationally.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
module cordic_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so it carries no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cordic_quadrant_ctrl.sv
// Reduces any signed degree angle to 0..90 for the CORDIC core and sign-corrects its results.
// Latency: issue 10 cycles after handshake (arctan: 1); result 1 cycle after cordic_out_valid.
// Backpressure: req_ready low while a request is in flight or the tag FIFO is full.
module cordic_quadrant_ctrl
    import cordic_ctrl_pkg::*;
#(
    parameter int TAG_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_angle,
    input  logic [15:0] req_another,
    input  logic [3:0]  req_select,
    output logic        cordic_valid,
    output logic [15:0] cordic_angle,
    output logic [15:0] cordic_another,
    output logic [3:0]  cordic_select,
    input  logic [15:0] cordic_out,
    input  logic        cordic_out_valid,
    output logic [15:0] res_data,
    output logic        res_valid,
    input  logic        err_clr,
    output logic [1:0]  err
);
    state_t      state;
    state_t      state_nxt;
    logic [15:0] angle_in;
    logic [16:0] r;
    logic [2:0]  k;
    quadrant_t   cur_q;
    quadrant_t   fold_q;
    logic [15:0] fold_f;
    logic        hs;
    logic        sel_legal;
    logic        tag_push;
    logic        tag_pop;
    tag_t        tag_in;
    tag_t        tag_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        orphan;
    logic [1:0]  err_nxt;

    assign req_ready    = rst_n && (state == ST_IDLE) && !fifo_full;
    assign hs           = req_valid && req_ready;
    assign sel_legal    = $onehot(req_select);
    assign cordic_valid = (state == ST_ISSUE);
    assign tag_push     = (state == ST_ISSUE);
    assign tag_in       = '{q: cur_q, sel: cordic_select};
    assign tag_pop      = cordic_out_valid && !fifo_empty;
    assign orphan       = cordic_out_valid && fifo_empty;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: arctan skips reduction; illegal selects are consumed in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (hs && sel_legal)
                    state_nxt = req_select[SEL_ATAN] ? ST_ISSUE : ST_NORM;
            end
            ST_NORM:   state_nxt = ST_REDUCE;
            ST_REDUCE: if (k == 3'd0) state_nxt = ST_FOLD;
            ST_FOLD:   state_nxt = ST_ISSUE;
            ST_ISSUE:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Fold the 0..359 remainder into quadrant and 0..90 angle
    always_comb begin
        fold_q = Q0;
        fold_f = r[15:0];
        if (r <= 17'd90) begin
            fold_q = Q0;
            fold_f = r[15:0];
        end else if (r <= 17'd180) begin
            fold_q = Q1;
            fold_f = 16'd180 - r[15:0];
        end else if (r <= 17'd270) begin
            fold_q = Q2;
            fold_f = r[15:0] - 16'd180;
        end else begin
            fold_q = Q3;
            fold_f = 16'd360 - r[15:0];
        end
    end

    // Request capture and modulo-360 reduction by restoring subtraction of 360<<k
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            angle_in       <= '0;
            r              <= '0;
            k              <= '0;
            cur_q          <= Q0;
            cordic_angle   <= '0;
            cordic_another <= '0;
            cordic_select  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hs && sel_legal) begin
                        angle_in       <= req_angle;
                        cordic_another <= req_another;
                        cordic_select  <= req_select;
                        cur_q          <= Q0;
                        if (req_select[SEL_ATAN]) cordic_angle <= req_angle;
                    end
                end
                ST_NORM: begin
                    r <= {angle_in[15], angle_in} + (angle_in[15] ? NORM_OFS : 17'd0);
                    k <= 3'd6;
                end
                ST_REDUCE: begin
                    if (r >= (DEG_360 << k)) r <= r - (DEG_360 << k);
                    k <= k - 3'd1;
                end
                ST_FOLD: begin
                    cordic_angle <= fold_f;
                    cur_q        <= fold_q;
                end
                default: ;
            endcase
        end
    end

    cordic_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH ($bits(tag_t))
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_push),
        .push_data (tag_in),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Result path: pair each returning result with its head tag and undo the fold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            res_valid <= tag_pop;
            if (tag_pop)
                res_data <= needs_neg(tag_head.sel, tag_head.q) ? sat_neg(cordic_out) : cordic_out;
        end
    end

    // Sticky errors; a new event in the clearing cycle still lands
    always_comb begin
        err_nxt = err_clr ? 2'b00 : err;
        if (orphan)                          err_nxt[0] = 1'b1;
        if (hs && !sel_legal)                err_nxt[1] = 1'b1;
    end

    // Error register
    always_ff @(posedge clk) begin
        if (!rst_n) err <= 2'b00;
        else        err <= err_nxt;
    end

endmodule

// File: tb/tb_cordic_quadrant_ctrl.sv
// Self-checking bench for cordic_quadrant_ctrl: directed table, random requests, corner sequences.
// Latency: n/a (testbench).
// Backpressure: waits on req_ready with a bounded cycle budget.
module tb_cordic_quadrant_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_angle;
    logic [15:0] req_another;
    logic [3:0]  req_select;
    logic        cordic_valid;
    logic [15:0] cordic_angle;
    logic [15:0] cordic_another;
    logic [3:0]  cordic_select;
    logic [15:0] cordic_out;
    logic        cordic_out_valid;
    logic [15:0] res_data;
    logic        res_valid;
    logic        err_clr;
    logic [1:0]  err;

    int total = 0;
    int bad   = 0;

    // Expected tags of requests outstanding in the core, oldest first
    logic [3:0] exp_sel_q[$];
    int         exp_quad_q[$];

    always #5 clk = ~clk;

    cordic_quadrant_ctrl #(.TAG_DEPTH(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_angle        (req_angle),
        .req_another      (req_another),
        .req_select       (req_select),
        .cordic_valid     (cordic_valid),
        .cordic_angle     (cordic_angle),
        .cordic_another   (cordic_another),
        .cordic_select    (cordic_select),
        .cordic_out       (cordic_out),
        .cordic_out_valid (cordic_out_valid),
        .res_data         (res_data),
        .res_valid        (res_valid),
        .err_clr          (err_clr),
        .err              (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: angle modulo 360 with plain integer arithmetic, then quadrant fold
    function automatic void ref_fold(input int a, output int f, output int q);
        int r;
        r = a % 360;
        if (r < 0) r += 360;
        if (r <= 90)       begin q = 0; f = r;       end
        else if (r <= 180) begin q = 1; f = 180 - r; end
        else if (r <= 270) begin q = 2; f = r - 180; end
        else               begin q = 3; f = 360 - r; end
    endfunction

    // Reference: sign of sin/cos/tan in each quadrant, with saturating negation
    function automatic logic [15:0] ref_fix(input logic [3:0] sel, input int q, input logic [15:0] v);
        bit neg;
        int s;
        neg = (sel == 4'b0001 && q >= 2) ||
              (sel == 4'b0010 && (q == 1 || q == 2)) ||
              (sel == 4'b0100 && (q == 1 || q == 3));
        if (!neg) return v;
        s = -int'($signed(v));
        if (s > 32767) s = 32767;
        return 16'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string nm);
        check({nm, " cordic_valid"},  32'(cordic_valid), 0);
        check({nm, " res_valid"},     32'(res_valid), 0);
        check({nm, " res_data"},      32'(res_data), 0);
        check({nm, " err"},           32'(err), 0);
        check({nm, " cordic_angle"},  32'(cordic_angle), 0);
        check({nm, " cordic_select"}, 32'(cordic_select), 0);
    endtask

    // Handshake one request and follow it to its issue pulse
    task automatic issue(input logic [15:0] ang, input logic [15:0] oth, input logic [3:0] sel,
                         input int exp_ang, input int exp_lat, input string nm);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin tick(); n++; end
        if (!req_ready) begin
            check({nm, " ready timeout"}, 0, 1);
            return;
        end
        req_valid = 1'b1; req_angle = ang; req_another = oth; req_select = sel;
        tick();
        req_valid = 1'b0; req_angle = 16'($urandom); req_select = 4'($urandom);
        n = 1;
        while (!cordic_valid && n < 30) begin tick(); n++; end
        check({nm, " issue cycle"}, 32'(n), 32'(exp_lat));
        if (cordic_valid) begin
            check({nm, " cordic_angle"},   32'(cordic_angle), 32'(exp_ang));
            check({nm, " cordic_select"},  32'(cordic_select), 32'(sel));
            check({nm, " cordic_another"}, 32'(cordic_another), 32'(oth));
        end
        tick();
        check({nm, " issue pulse width"}, 32'(cordic_valid), 0);
    endtask

    // Return one result from the core and check the corrected value and strobe shape
    task automatic result(input logic [15:0] v, input logic [15:0] exp, input string nm);
        cordic_out_valid = 1'b1; cordic_out = v;
        tick();
        cordic_out_valid = 1'b0; cordic_out = 16'($urandom);
        check({nm, " res_valid"}, 32'(res_valid), 1);
        check({nm, " res_data"},  32'(res_data), 32'(exp));
        tick();
        check({nm, " res_valid low"}, 32'(res_valid), 0);
        check({nm, " res_data hold"}, 32'(res_data), 32'(exp));
    endtask

    // Random legal request; expected tag recorded for a later result
    task automatic random_issue(input string nm);
        logic [15:0] ang;
        logic [3:0]  sel;
        int f, q;
        ang = 16'($urandom);
        sel = 4'b0001 << $urandom_range(0, 3);
        ref_fold(int'($signed(ang)), f, q);
        if (sel == 4'b1000) begin
            f = int'(ang);
            q = 0;
        end
        issue(ang, 16'($urandom), sel, f, (sel == 4'b1000) ? 1 : 10, nm);
        exp_sel_q.push_back(sel);
        exp_quad_q.push_back(q);
    endtask

    task automatic random_result(input string nm);
        logic [15:0] v;
        v = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
        result(v, ref_fix(exp_sel_q.pop_front(), exp_quad_q.pop_front(), v), nm);
    endtask

    typedef struct {
        logic [15:0] angle;
        logic [3:0]  sel;
        logic [15:0] out;
        int          exp_ang;
        logic [15:0] exp_res;
    } vec_t;

    vec_t vt[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vt[0] = '{16'd30,   4'b0001, 16'h0080, 30,   16'h0080};
        vt[1] = '{16'd150,  4'b0010, 16'h00DD, 30,   16'hFF23};
        vt[2] = '{16'hFFE2, 4'b0001, 16'h0080, 30,   16'hFF80};
        vt[3] = '{16'h7FFF, 4'b0001, 16'h0100, 7,    16'h0100};
        vt[4] = '{16'h8000, 4'b0001, 16'h0040, 8,    16'hFFC0};
        vt[5] = '{16'd90,   4'b0010, 16'h0100, 90,   16'h0100};
        vt[6] = '{16'd180,  4'b0100, 16'h8000, 0,    16'h7FFF};
        vt[7] = '{16'd270,  4'b0001, 16'h0100, 90,   16'hFF00};
        vt[8] = '{16'd1234, 4'b1000, 16'h8000, 1234, 16'h8000};

        rst_n = 1'b0; req_valid = 1'b0; req_angle = '0; req_another = '0; req_select = '0;
        cordic_out = '0; cordic_out_valid = 1'b0; err_clr = 1'b0;
        tick(); tick();
        check_reset_state("reset");
        rst_n = 1'b1;
        tick();
        check("ready after reset", 32'(req_ready), 1);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            issue(vt[i].angle, 16'hA5A5 ^ 16'(i), vt[i].sel, vt[i].exp_ang,
                  vt[i].sel[3] ? 1 : 10, nm);
            result(vt[i].out, vt[i].exp_res, nm);
        end

        // Random requests, each returned immediately
        for (int i = 0; i < 24; i++) begin
            random_issue($sformatf("rnd%0d", i));
            random_result($sformatf("rnd%0d", i));
        end

        // Fill all tags, then free one slot
        for (int i = 0; i < 8; i++) random_issue($sformatf("fill%0d", i));
        check("ready when full", 32'(req_ready), 0);
        tick();
        check("ready still full", 32'(req_ready), 0);
        begin
            logic [15:0] v, e;
            v = 16'($urandom);
            e = ref_fix(exp_sel_q.pop_front(), exp_quad_q.pop_front(), v);
            cordic_out_valid = 1'b1; cordic_out = v;
            tick();
            cordic_out_valid = 1'b0;
            check("ready after pop", 32'(req_ready), 1);
            check("drain0 res_valid", 32'(res_valid), 1);
            check("drain0 res_data", 32'(res_data), 32'(e));
            tick();
        end
        for (int i = 1; i < 8; i++) random_result($sformatf("drain%0d", i));

        // Orphan result, clear, and set-wins-over-clear
        cordic_out_valid = 1'b1; cordic_out = 16'h1234;
        tick();
        cordic_out_valid = 1'b0;
        check("orphan res_valid", 32'(res_valid), 0);
        check("orphan err", 32'(err), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err cleared", 32'(err), 0);
        err_clr = 1'b1; cordic_out_valid = 1'b1;
        tick();
        err_clr = 1'b0; cordic_out_valid = 1'b0;
        check("set wins over clear", 32'(err), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Illegal select is consumed without issuing
        req_valid = 1'b1; req_angle = 16'd45; req_select = 4'b0011;
        tick();
        req_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (cordic_valid) cnt++;
            tick();
        end
        check("illegal no issue", 32'(cnt), 0);
        check("illegal err", 32'(err), 32'h2);
        check("illegal ready", 32'(req_ready), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Reset in the middle of a reduction drops the request
        req_valid = 1'b1; req_angle = 16'd200; req_select = 4'b0001;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        check_reset_state("midreset");
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (cordic_valid) cnt++;
            tick();
        end
        check("midreset no issue", 32'(cnt), 0);
        cordic_out_valid = 1'b1; cordic_out = 16'h0055;
        tick();
        cordic_out_valid = 1'b0;
        check("midreset orphan res_valid", 32'(res_valid), 0);
        check("midreset orphan err", 32'(err), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
